// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch stage.
// Build option: define FETCH_PERF_CNT_EN to add the performance counters to fetch_unit.
package fetch_pkg;

    localparam int DEFAULT_ADDR_W  = 64;
    localparam int DEFAULT_INSTR_W = 32;
    localparam int DEFAULT_PC_STEP = 4;
    localparam int PERF_W          = 32;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0]  pc;
        logic [DEFAULT_INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Saturating add used by the performance counters: sticks at all-ones.
    function automatic logic [PERF_W-1:0] sat_add(input logic [PERF_W-1:0] a,
                                                  input logic [PERF_W-1:0] b);
        logic [PERF_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[PERF_W] ? '1 : sum[PERF_W-1:0];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush, occupancy count and same-cycle push/pop.
// Used both as the pc-tag queue and as the fetched-instruction buffer.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Pointer/count update; a full FIFO still accepts a push when it pops in the same cycle.
    always_comb begin
        do_push  = push && (!full || pop);
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful under the valid count, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// LEGv8 instruction-fetch stage: owns the PC, issues imem requests under a credit
// limit, buffers responses in order and squashes in-flight fetches on a redirect.
// Build option: define FETCH_PERF_CNT_EN to add perf_fetched/perf_stall_cycles/perf_squashed.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = DEFAULT_ADDR_W,
    parameter int                INSTR_W    = DEFAULT_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                PC_STEP    = DEFAULT_PC_STEP,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]  perf_fetched,
    output logic [PERF_W-1:0]  perf_stall_cycles,
    output logic [PERF_W-1:0]  perf_squashed
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   buf_count;
    logic [CNT_W:0]     credit_used;
    logic [ADDR_W-1:0]  tag_pc;
    logic [ADDR_W+INSTR_W-1:0] buf_head;
    logic               req_fire;
    logic               rsp_drop;
    logic               buf_push;
    logic               buf_pop;

    // The tag queue occupancy is the number of in-flight requests; it pops on every
    // response, dropped or not, so it is never flushed by a redirect.
    fetch_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_q (
        .clk       (clk),
        .reset     (reset),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (imem_rsp_valid),
        .head_data (tag_pc),
        .count     (outstanding)
    );

    fetch_fifo #(
        .WIDTH (ADDR_W + INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_buf_q (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (buf_push),
        .push_data ({tag_pc, imem_rsp_data}),
        .pop       (buf_pop),
        .head_data (buf_head),
        .count     (buf_count)
    );

    assign {if_pc, if_instr} = buf_head;

    // Handshakes, next PC, drop accounting and FETCH/DRAIN transitions.
    always_comb begin
        credit_used    = {1'b0, outstanding} + {1'b0, buf_count};
        imem_req_valid = !reset && (state_q == FETCH) && !redirect_valid &&
                         (credit_used < (CNT_W+1)'(FIFO_DEPTH));
        imem_req_addr  = pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_drop       = imem_rsp_valid && (redirect_valid || (drop_cnt_q != '0));
        buf_push       = imem_rsp_valid && !rsp_drop;
        if_valid       = (buf_count != '0);
        buf_pop        = if_valid && if_ready;

        pc_d       = pc_q;
        drop_cnt_d = drop_cnt_q;
        state_d    = state_q;

        if (redirect_valid) begin
            pc_d       = redirect_pc;
            drop_cnt_d = outstanding - CNT_W'(imem_rsp_valid);
            state_d    = (drop_cnt_d != '0) ? DRAIN : FETCH;
        end else begin
            if (req_fire) pc_d = pc_q + ADDR_W'(PC_STEP);
            if (rsp_drop) drop_cnt_d = drop_cnt_q - CNT_W'(1);
            case (state_q)
                FETCH:   state_d = FETCH;
                DRAIN:   if (drop_cnt_d == '0) state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end
    end

    // Architectural state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [PERF_W-1:0] fetched_q, fetched_d;
    logic [PERF_W-1:0] stall_q, stall_d;
    logic [PERF_W-1:0] squashed_q, squashed_d;
    logic [CNT_W-1:0]  flushed;

    // Counter increments; a redirect flushes whatever the same-cycle pop leaves behind.
    always_comb begin
        flushed    = redirect_valid ? (buf_count - CNT_W'(buf_pop)) : '0;
        fetched_d  = sat_add(fetched_q, PERF_W'(buf_push));
        stall_d    = sat_add(stall_q, PERF_W'(if_valid && !if_ready));
        squashed_d = sat_add(squashed_q, PERF_W'(rsp_drop) + PERF_W'(flushed));
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetched_q  <= '0;
            stall_q    <= '0;
            squashed_q <= '0;
        end else begin
            fetched_q  <= fetched_d;
            stall_q    <= stall_d;
            squashed_q <= squashed_d;
        end
    end

    assign perf_fetched      = fetched_q;
    assign perf_stall_cycles = stall_q;
    assign perf_squashed     = squashed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model with configurable latency and a
// request budget drives the DUT; expected requests and IF/ID entries are queued by the
// stimulus and a separate monitor pops/compares whenever decode accepts an entry.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 2;

    logic               clk;
    logic               reset;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               if_valid;
    logic               if_ready;
    logic [ADDR_W-1:0]  if_pc;
    logic [INSTR_W-1:0] if_instr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]        perf_fetched;
    logic [31:0]        perf_stall_cycles;
    logic [31:0]        perf_squashed;
`endif

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                due;
    } pend_t;

    pend_t             pend_q[$];
    fetch_entry_t      exp_if_q[$];
    logic [ADDR_W-1:0] exp_req_q[$];

    int                n_checks;
    int                n_fail;
    int                cyc;
    int                latency;
    int                budget;
    int                n_req_fired;
    logic              want_ready;
    logic              redir_req;
    logic [ADDR_W-1:0] redir_target;

    fetch_unit #(
        .ADDR_W     (ADDR_W),
        .INSTR_W    (INSTR_W),
        .RESET_PC   (64'h0),
        .PC_STEP    (4),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched      (perf_fetched),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_squashed     (perf_squashed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: opcode-like top byte plus the low address bits.
    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        return 32'h8B00_0000 | {8'h00, a[23:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expectReq(input logic [ADDR_W-1:0] a);
        exp_req_q.push_back(a);
    endtask

    task automatic expectIf(input logic [ADDR_W-1:0] a);
        exp_if_q.push_back('{pc: a, instr: mem_word(a)});
    endtask

    // One clock cycle: drive inputs just after the rising edge, observe the request
    // handshake at the falling edge.
    task automatic applyStimulus(input int n);
        pend_t p;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                p = pend_q.pop_front();
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(p.addr);
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
            imem_req_ready = (budget > 0);
            if_ready       = want_ready;
            redirect_valid = redir_req;
            redirect_pc    = redir_target;
            redir_req      = 1'b0;
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                if (exp_req_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL req_unexpected: got request 0x%0h, required none", imem_req_addr);
                end else begin
                    checkOutput("req_addr", imem_req_addr, exp_req_q.pop_front());
                end
                pend_q.push_back('{addr: imem_req_addr, due: cyc + latency});
                budget--;
                n_req_fired++;
            end
        end
    endtask

    // Reset the DUT, abandon everything in flight and check the reset outputs.
    task automatic resetDut();
        @(posedge clk);
        #1;
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        if_ready       = 1'b1;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        redir_req      = 1'b0;
        budget         = 0;
        n_req_fired    = 0;
        pend_q.delete();
        exp_if_q.delete();
        exp_req_q.delete();
        @(negedge clk);
        checkOutput("rst_req_valid", 64'(imem_req_valid), 64'd0);
        checkOutput("rst_if_valid", 64'(if_valid), 64'd0);
        @(posedge clk);
        #1;
        imem_req_ready = 1'b0;
        reset          = 1'b0;
        cyc            = -1;
    endtask

    // Run until every expected entry has been delivered, bounded by a cycle budget.
    task automatic waitDrain(input string name);
        int k;
        k = 0;
        while ((exp_if_q.size() != 0 || pend_q.size() != 0) && k < 300) begin
            applyStimulus(1);
            k++;
        end
        applyStimulus(4);
        checkOutput({name, "_if_left"}, 64'(exp_if_q.size()), 64'd0);
        checkOutput({name, "_req_left"}, 64'(exp_req_q.size()), 64'd0);
    endtask

    // Monitor: compare every accepted IF/ID entry against the scoreboard.
    initial begin
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && if_valid && if_ready) begin
                if (exp_if_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL if_unexpected: got pc 0x%0h instr 0x%0h, required none",
                             if_pc, if_instr);
                end else begin
                    e = exp_if_q.pop_front();
                    checkOutput("if_pc", if_pc, e.pc);
                    checkOutput("if_instr", 64'(if_instr), 64'(e.instr));
                end
            end
        end
    end

    // Hard stop in case something unforeseen blocks the stimulus.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        n_checks       = 0;
        n_fail         = 0;
        cyc            = -1;
        latency        = 1;
        budget         = 0;
        n_req_fired    = 0;
        want_ready     = 1'b1;
        redir_req      = 1'b0;
        redir_target   = '0;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if_ready       = 1'b1;

        // Sequential fetch from reset with 1-cycle memory.
        resetDut();
        latency    = 1;
        want_ready = 1'b1;
        budget     = 6;
        for (int i = 0; i < 6; i++) begin
            expectReq(64'(i * 4));
            expectIf(64'(i * 4));
        end
        waitDrain("seq");
`ifdef FETCH_PERF_CNT_EN
        checkOutput("perf_fetched", 64'(perf_fetched), 64'd6);
`endif

        // Decode stall: two credits fill, issue stops, head is held.
        resetDut();
        latency    = 1;
        want_ready = 1'b0;
        budget     = 4;
        for (int i = 0; i < 4; i++) begin
            expectReq(64'(i * 4));
            expectIf(64'(i * 4));
        end
        applyStimulus(2);
        for (int i = 2; i < 10; i++) begin
            applyStimulus(1);
            checkOutput("stall_if_valid", 64'(if_valid), 64'd1);
            checkOutput("stall_if_pc", if_pc, 64'h0);
            checkOutput("stall_if_instr", 64'(if_instr), 64'h8B00_0000);
        end
        checkOutput("stall_req_valid", 64'(imem_req_valid), 64'd0);
        checkOutput("stall_issued", 64'(n_req_fired), 64'd2);
        want_ready = 1'b1;
        applyStimulus(1);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("perf_stall_cycles", 64'(perf_stall_cycles), 64'd8);
`endif
        waitDrain("stall");

        // Redirect with two 3-cycle fetches in flight.
        resetDut();
        latency      = 3;
        want_ready   = 1'b1;
        redir_req    = 1'b1;
        redir_target = 64'h10;
        applyStimulus(1);
        budget = 2;
        expectReq(64'h10);
        expectReq(64'h14);
        applyStimulus(2);
        redir_req    = 1'b1;
        redir_target = 64'h100;
        budget       = 2;
        expectReq(64'h100);
        expectReq(64'h104);
        expectIf(64'h100);
        expectIf(64'h104);
        applyStimulus(1);
        checkOutput("redir_req_valid", 64'(imem_req_valid), 64'd0);
        applyStimulus(1);
        checkOutput("drain1_req_valid", 64'(imem_req_valid), 64'd0);
        checkOutput("drain1_if_valid", 64'(if_valid), 64'd0);
        applyStimulus(1);
        checkOutput("drain2_req_valid", 64'(imem_req_valid), 64'd0);
        checkOutput("drain2_if_valid", 64'(if_valid), 64'd0);
        waitDrain("redir");
`ifdef FETCH_PERF_CNT_EN
        checkOutput("perf_squashed_redir", 64'(perf_squashed), 64'd2);
`endif

        // Redirect in the same cycle as a response.
        resetDut();
        latency    = 2;
        want_ready = 1'b1;
        budget     = 2;
        expectReq(64'h0);
        expectReq(64'h4);
        applyStimulus(2);
        redir_req    = 1'b1;
        redir_target = 64'h200;
        budget       = 1;
        expectReq(64'h200);
        expectIf(64'h200);
        applyStimulus(1);
        applyStimulus(1);
        checkOutput("same_drain_req_valid", 64'(imem_req_valid), 64'd0);
        checkOutput("same_drain_if_valid", 64'(if_valid), 64'd0);
        waitDrain("same_cycle");
`ifdef FETCH_PERF_CNT_EN
        checkOutput("perf_squashed_same", 64'(perf_squashed), 64'd2);
`endif

        // PC wrap at the top of the address space.
        resetDut();
        latency      = 1;
        want_ready   = 1'b1;
        redir_req    = 1'b1;
        redir_target = 64'hFFFF_FFFF_FFFF_FFF8;
        applyStimulus(1);
        budget = 3;
        expectReq(64'hFFFF_FFFF_FFFF_FFF8);
        expectReq(64'hFFFF_FFFF_FFFF_FFFC);
        expectReq(64'h0);
        expectIf(64'hFFFF_FFFF_FFFF_FFF8);
        expectIf(64'hFFFF_FFFF_FFFF_FFFC);
        expectIf(64'h0);
        waitDrain("wrap");

        // Reset with fetches in flight, then restart from the reset PC.
        resetDut();
        latency    = 3;
        want_ready = 1'b1;
        budget     = 2;
        expectReq(64'h0);
        expectReq(64'h4);
        applyStimulus(3);
        resetDut();
        latency = 1;
        budget  = 2;
        expectReq(64'h0);
        expectReq(64'h4);
        expectIf(64'h0);
        expectIf(64'h4);
        waitDrain("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
